// File: rtl/serial_parity_rx_if.sv
// Serial receive bundle: sampled line in, reassembled word and frame status out.
interface serial_parity_rx_if #(
  parameter int DATA_W = 8
);
  logic              din;
  logic              din_valid;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              parity_err;
  logic              frame_err;

  modport master (
    output din, din_valid,
    input  dout, dout_valid, parity_err, frame_err
  );

  modport slave (
    input  din, din_valid,
    output dout, dout_valid, parity_err, frame_err
  );
endinterface

// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, parity bit, stop bit.
// Reports the reassembled word with parity and framing status at each frame end.
module serial_parity_rx #(
  parameter int DATA_W = 8,
  parameter int ODD    = 0
) (
  input  logic               clk,
  input  logic               rst,
  serial_parity_rx_if.slave  bus
);
  localparam int   CNT_W   = $clog2(DATA_W + 1);
  localparam logic ODD_BIT = (ODD != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                acc_q, acc_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                parity_err_q, parity_err_d;
  logic                frame_err_q, frame_err_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    acc_d        = acc_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    if (bus.din_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (!bus.din) begin
            state_d = S_DATA;
            cnt_d   = '0;
            acc_d   = 1'b0;
          end
        end
        S_DATA: begin
          // Compare-per-bit keeps the write position free of index-width mismatch.
          for (int unsigned i = 0; i < DATA_W; i++) begin
            if (cnt_q == CNT_W'(i)) shift_d[i] = bus.din;
          end
          acc_d = acc_q ^ bus.din;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = S_PARITY;
        end
        S_PARITY: begin
          acc_d   = acc_q ^ bus.din;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d      = S_IDLE;
          dout_d       = shift_q;
          parity_err_d = acc_q ^ ODD_BIT;
          frame_err_d  = ~bus.din;
          dout_valid_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      acc_q        <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      acc_q        <= acc_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed bench for serial_parity_rx: an 8-bit even-parity and a 4-bit odd-parity instance.
module tb_serial_parity_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   p8 = 0;
  int   p4 = 0;
  int   base;
  int   pt8[$];
  logic [7:0] pd8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  serial_parity_rx_if #(.DATA_W(8)) b8 ();
  serial_parity_rx_if #(.DATA_W(4)) b4 ();

  serial_parity_rx #(.DATA_W(8), .ODD(0)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  serial_parity_rx #(.DATA_W(4), .ODD(1)) dut4 (.clk(clk), .rst(rst), .bus(b4));

  always @(negedge clk) begin
    if (b8.dout_valid) begin
      p8++;
      pt8.push_back(cyc);
      pd8.push_back(b8.dout);
    end
    if (b4.dout_valid) p4++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic b, input logic v);
    @(negedge clk);
    if (sel == 8) begin
      b8.din = b; b8.din_valid = v;
    end else begin
      b4.din = b; b4.din_valid = v;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      b8.din = 1'b1; b8.din_valid = 1'b0;
      b4.din = 1'b1; b4.din_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input int sel, input logic [15:0] data, input int w,
                            input logic par, input logic stop, input int stride);
    logic [19:0] bits;
    bits = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < w; i++) bits[i+1] = data[i];
    bits[w+1] = par;
    bits[w+2] = stop;
    for (int i = 0; i < w + 3; i++) begin
      for (int k = 1; k < stride; k++) drive(sel, 1'($urandom_range(0, 1)), 1'b0);
      drive(sel, bits[i], 1'b1);
    end
  endtask

  initial begin
    b8.din = 1'b1; b8.din_valid = 1'b0;
    b4.din = 1'b1; b4.din_valid = 1'b0;
    idle(2);
    check("rst_dout", b8.dout, 0);
    check("rst_valid", b8.dout_valid, 0);
    check("rst_perr", b8.parity_err, 0);
    check("rst_ferr", b8.frame_err, 0);
    rst = 1'b0;
    idle(2);

    // Nominal 0xA5 frame
    base = p8;
    send_frame(8, 16'hA5, 8, 1'b0, 1'b1, 1);
    check("nom_not_early", b8.dout_valid, 0);
    idle(1);
    check("nom_valid", b8.dout_valid, 1);
    check("nom_dout", b8.dout, 32'hA5);
    check("nom_perr", b8.parity_err, 0);
    check("nom_ferr", b8.frame_err, 0);
    idle(1);
    check("nom_valid_drop", b8.dout_valid, 0);
    check("nom_pulses", p8 - base, 1);

    // Bad parity bit
    base = p8;
    send_frame(8, 16'hA5, 8, 1'b1, 1'b1, 1);
    idle(1);
    check("par_valid", b8.dout_valid, 1);
    check("par_dout", b8.dout, 32'hA5);
    check("par_perr", b8.parity_err, 1);
    check("par_ferr", b8.frame_err, 0);
    idle(1);
    check("par_pulses", p8 - base, 1);

    // Stop bit 0
    base = p8;
    send_frame(8, 16'hA5, 8, 1'b0, 1'b0, 1);
    idle(1);
    check("stop_valid", b8.dout_valid, 1);
    check("stop_ferr", b8.frame_err, 1);
    check("stop_perr", b8.parity_err, 0);
    idle(5);
    check("stop_pulses", p8 - base, 1);
    check("hold_ferr", b8.frame_err, 1);
    check("hold_dout", b8.dout, 32'hA5);

    // Sparse strobes with noise between them
    base = p8;
    send_frame(8, 16'hA5, 8, 1'b0, 1'b1, 3);
    idle(1);
    check("sparse_valid", b8.dout_valid, 1);
    check("sparse_dout", b8.dout, 32'hA5);
    check("sparse_perr", b8.parity_err, 0);
    check("sparse_ferr", b8.frame_err, 0);
    idle(1);
    check("sparse_pulses", p8 - base, 1);

    // Reset during the 4th data bit, then a clean 0x3C frame
    base = p8;
    drive(8, 1'b0, 1'b1);
    drive(8, 1'b1, 1'b1);
    drive(8, 1'b0, 1'b1);
    drive(8, 1'b1, 1'b1);
    drive(8, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_dout", b8.dout, 0);
    check("arst_valid", b8.dout_valid, 0);
    check("arst_perr", b8.parity_err, 0);
    check("arst_ferr", b8.frame_err, 0);
    idle(2);
    rst = 1'b0;
    idle(1);
    send_frame(8, 16'h3C, 8, 1'b0, 1'b1, 1);
    idle(1);
    check("post_rst_dout", b8.dout, 32'h3C);
    check("post_rst_perr", b8.parity_err, 0);
    check("post_rst_ferr", b8.frame_err, 0);
    idle(1);
    check("post_rst_pulses", p8 - base, 1);

    // Idle line, then back-to-back frames
    base = p8;
    repeat (20) drive(8, 1'b1, 1'b1);
    idle(1);
    check("idle_no_pulse", p8 - base, 0);
    pt8.delete();
    pd8.delete();
    send_frame(8, 16'hFF, 8, 1'b0, 1'b1, 1);
    send_frame(8, 16'h01, 8, 1'b1, 1'b1, 1);
    idle(2);
    check("b2b_pulses", p8 - base, 2);
    if (pt8.size() == 2 && pd8.size() == 2) begin
      check("b2b_first", pd8[0], 32'hFF);
      check("b2b_second", pd8[1], 32'h01);
      check("b2b_spacing", pt8[1] - pt8[0], 11);
    end else begin
      check("b2b_capture_count", pt8.size(), 2);
    end
    check("b2b_perr", b8.parity_err, 0);
    check("b2b_ferr", b8.frame_err, 0);

    // Odd parity, 4-bit instance
    base = p4;
    send_frame(4, 16'h0, 4, 1'b1, 1'b1, 1);
    idle(1);
    check("odd_valid", b4.dout_valid, 1);
    check("odd_dout", b4.dout, 0);
    check("odd_perr", b4.parity_err, 0);
    check("odd_ferr", b4.frame_err, 0);
    send_frame(4, 16'h0, 4, 1'b0, 1'b1, 1);
    idle(1);
    check("odd_bad_perr", b4.parity_err, 1);
    idle(1);
    check("odd_pulses", p4 - base, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_parity_rx.md
# serial_parity_rx

Serial frame receiver with parity check. It accepts one bit per sample strobe and deserializes a start bit, DATA_W data bits (LSB first), one parity bit and one stop bit. A running XOR accumulates parity as the bits arrive. It is the receiving end for the parity-generating XOR gates in the block library: it reassembles the word and reports parity and framing errors to the downstream logic.

## Interface
Parameters:
- DATA_W, 8: data bits per frame (legal range 1..16)
- ODD, 0: parity mode. 0 = even (XOR over data and parity bit must be 0); 1 = odd (XOR must be 1)

Ports (clock and reset listed first):
- clk  input  1  single clock; all logic is on the rising edge
- rst  input  1  asynchronous, active-high reset
- din  input  1  serial line; idle level is 1
- din_valid  input  1  sample strobe; din is consumed only on edges where din_valid=1
- dout  output  DATA_W  last received data word
- dout_valid  output  1  one-cycle pulse marking frame completion
- parity_err  output  1  parity status of the last frame
- frame_err  output  1  stop bit of the last frame was 0

## Operation
- State machine: IDLE, DATA, PARITY, STOP. All transitions occur only on edges with din_valid=1; with din_valid=0 the state, bit counter, shift register and accumulator hold.
- IDLE: din=1 → stay in IDLE. din=0 (start bit) → DATA; clear the bit counter and accumulator.
- DATA:
  - Shift din into the shift register at position bit_cnt (LSB first).
  - acc ← acc ^ din.
  - After the DATA_W-th bit → PARITY.
- PARITY: acc ← acc ^ din → STOP.
- STOP: sample the stop bit, then always return to IDLE. A 0 stop bit is not treated as a new start bit.
- Frame completion (on the STOP sampling edge):
  - dout ← shift register.
  - parity_err ← acc ^ ODD, where acc already includes the parity bit.
  - frame_err ← ~din.
  - dout_valid ← 1.
- dout_valid always pulses at the end of a frame, even when an error is flagged.
- dout, parity_err and frame_err hold until the next frame completes.
- bit_cnt is $clog2(DATA_W+1) bits wide. No wrap-around: the counter is cleared on each start bit.

## Timing
- Reset (asynchronous, any state, including mid-frame):
  - State → IDLE; counter, shift register and accumulator cleared.
  - dout=0, dout_valid=0, parity_err=0, frame_err=0.
  - A partial frame is discarded and no pulse is emitted.
- Latency: dout_valid rises in the cycle following the clock edge that samples the stop bit. dout, parity_err and frame_err are valid in that same cycle.
- dout_valid is high for exactly one clk cycle, regardless of din_valid in the next cycle.
- A frame occupies DATA_W+3 strobes. At minimum spacing (din_valid tied high), back-to-back frames are accepted with no dead strobe: the strobe after STOP may be the next start bit.
- No handshake or backpressure. The consumer must capture dout while dout_valid=1 or before the next frame completes.

## Test plan
- Nominal frame, DATA_W=8, ODD=0, din_valid=1 every cycle. Send 0, then 1,0,1,0,0,1,0,1 (data), then 0 (parity), then 1 (stop) → dout=0xA5, one dout_valid pulse 1 cycle after the stop edge, parity_err=0, frame_err=0.
- Same frame with parity bit 1 → dout=0xA5, parity_err=1, frame_err=0. Same frame with stop bit 0 → frame_err=1, parity_err=0. In both cases dout_valid still pulses once.
- Same 0xA5 frame with din_valid high only every 3rd cycle, and din toggled randomly on the non-strobe cycles → identical result: dout=0xA5, no errors.
- Reset during the 4th data bit of a frame → all outputs 0 immediately, with no clk edge needed. Then send a full 0x3C frame (parity bit 0, stop 1) → dout=0x3C, no errors, exactly one pulse.
- Idle line: din=1 for 20 strobes → no dout_valid. Then two back-to-back frames, 0xFF (parity 0) and 0x01 (parity 1) → two pulses 11 cycles apart, dout 0xFF then 0x01, no errors.
- ODD=1, DATA_W=4: send data 0000 with parity bit 1, stop 1 → dout=0x0, parity_err=0. The same frame with parity bit 0 → parity_err=1.
